// File: rtl/wl_seq_pkg.sv
// Shared types and helpers for the wordline pulse sequencer.
// The sequencer handles one-hot grants from a fixed four-wordline encoder.
package wl_seq_pkg;

    localparam int N_WL  = 4;
    localparam int IDX_W = $clog2(N_WL);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } wl_seq_state_t;

    function automatic logic is_onehot(input logic [N_WL-1:0] v);
        return (v != '0) && ((v & (v - N_WL'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_WL-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_WL; i++) begin
            if (v[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wl_idx_fifo.sv
// Small synchronous FIFO holding wordline indices.
// Read data is combinational from the head entry.
module wl_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wl_pulse_sequencer.sv
// Queues encoder grants and drives one wordline pulse at a time with enforced gaps.
// Flags malformed grants and queue overflow, and reports stream completion once drained.
module wl_pulse_sequencer
    import wl_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PULSE_W    = 4,
    parameter int GAP_W      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_WL-1:0] wl_i,
    input  logic            done_i,
    output logic [N_WL-1:0] wl_en,
    output logic            busy,
    output logic            seq_done,
    output logic            err_onehot,
    output logic            overflow,
    output logic [7:0]      pulse_cnt
);

    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    wl_seq_state_t   state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [N_WL-1:0] wl_en_d;
    logic [7:0]      pulse_cnt_d;
    logic            grant_ok, multi, push, pop;
    logic            full, empty;
    logic [IDX_W-1:0] dout;
    logic            done_q, done_rise, done_pending, seq_done_d;

    assign grant_ok  = is_onehot(wl_i);
    assign multi     = (wl_i != '0) && !grant_ok;
    assign push      = grant_ok && (!full || pop);
    assign done_rise = done_i && !done_q;
    assign busy      = (state != IDLE) || !empty;

    wl_idx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDX_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (onehot_to_idx(wl_i)),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        wl_en_d     = wl_en;
        pulse_cnt_d = pulse_cnt;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    wl_en_d = N_WL'(1) << dout;
                    cnt_d   = CNT_W'(PULSE_W - 1);
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    wl_en_d = '0;
                    cnt_d   = CNT_W'(GAP_W - 1);
                    if (pulse_cnt != 8'hFF) pulse_cnt_d = pulse_cnt + 8'd1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        wl_en_d = N_WL'(1) << dout;
                        cnt_d   = CNT_W'(PULSE_W - 1);
                        state_d = PULSE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                wl_en_d = '0;
            end
        endcase
        // Judged on the state being entered, so seq_done lands in the first IDLE cycle.
        seq_done_d = done_pending && (state_d == IDLE) && empty && !push;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wl_en        <= '0;
            pulse_cnt    <= '0;
            seq_done     <= 1'b0;
            err_onehot   <= 1'b0;
            overflow     <= 1'b0;
            done_q       <= 1'b0;
            done_pending <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            wl_en      <= wl_en_d;
            pulse_cnt  <= pulse_cnt_d;
            seq_done   <= seq_done_d;
            err_onehot <= err_onehot | multi;
            overflow   <= overflow | (grant_ok && full && !pop);
            done_q     <= done_i;
            if (done_rise)       done_pending <= 1'b1;
            else if (seq_done_d) done_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wl_pulse_sequencer.sv
// Scoreboard bench for wl_pulse_sequencer: expected grants queued at drive time,
// observed pulses captured by a negedge monitor and compared per scenario.
module tb_wl_pulse_sequencer;

    localparam int PULSE_W = 4;
    localparam int GAP_W   = 2;
    localparam int DEPTH   = 4;

    logic       clk;
    logic       rst;
    logic [3:0] wl_i;
    logic       done_i;
    logic [3:0] wl_en;
    logic       busy;
    logic       seq_done;
    logic       err_onehot;
    logic       overflow;
    logic [7:0] pulse_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        logic [3:0] val;
        int         start;
        int         width;
        int         gap;
    } pulse_t;

    pulse_t     obs_q[$];
    int         sd_q[$];
    logic [3:0] exp_q[$];

    wl_pulse_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .PULSE_W    (PULSE_W),
        .GAP_W      (GAP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wl_i       (wl_i),
        .done_i     (done_i),
        .wl_en      (wl_en),
        .busy       (busy),
        .seq_done   (seq_done),
        .err_onehot (err_onehot),
        .overflow   (overflow),
        .pulse_cnt  (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: a pulse cut short by reset is discarded.
    pulse_t cur;
    logic   in_pulse = 1'b0;
    int     last_end = -1000;
    always @(negedge clk) begin
        if (!rst) begin
            in_pulse = 1'b0;
            last_end = -1000;
        end else begin
            if (seq_done) sd_q.push_back(cyc);
            if (in_pulse && wl_en != cur.val) begin
                cur.width = cyc - cur.start;
                obs_q.push_back(cur);
                in_pulse = 1'b0;
                last_end = cyc;
            end
            if (!in_pulse && wl_en != 4'b0000) begin
                cur.val   = wl_en;
                cur.start = cyc;
                cur.gap   = cyc - last_end;
                in_pulse  = 1'b1;
            end
        end
    end

    task automatic do_reset();
        wl_i   = '0;
        done_i = 1'b0;
        rst    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        obs_q.delete();
        sd_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        for (int i = 0; i < budget && obs_q.size() < n; i++) @(posedge clk);
        #1;
        tests_run++;
        if (obs_q.size() < n) begin
            tests_failed++;
            $display("FAIL %s timeout: pulses seen %0d required %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        wl_i   = '0;
        done_i = 1'b0;
        rst    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({wl_en, busy, seq_done, err_onehot, overflow} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got wl_en=%b busy=%b seq_done=%b err=%b ovf=%b required all 0",
                     wl_en, busy, seq_done, err_onehot, overflow);
        end
        tests_run++;
        if (pulse_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_pulse_cnt: got %0d required 0", pulse_cnt);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({wl_en, busy, seq_done} !== 6'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got wl_en=%b busy=%b seq_done=%b required 0", wl_en, busy, seq_done);
        end
    endtask

    task automatic test_single();
        int     c0;
        pulse_t p;
        do_reset();
        @(posedge clk); #1;
        wl_i = 4'b0001;
        exp_q.push_back(4'b0001);
        c0 = cyc;
        @(posedge clk); #1;
        wl_i   = '0;
        done_i = 1'b1;
        for (int i = 0; i < 40 && sd_q.size() == 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        wait_pulses(1, 1, "single_pulse");
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            p = obs_q.pop_front();
            tests_run++;
            if (p.val !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL single_val: got %b required %b", p.val, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tests_run++;
            if (p.start - c0 != 2 || p.width != PULSE_W) begin
                tests_failed++;
                $display("FAIL single_timing: start %0d width %0d required start 2 width %0d",
                         p.start - c0, p.width, PULSE_W);
            end
        end
        tests_run++;
        if (sd_q.size() != 1) begin
            tests_failed++;
            $display("FAIL single_seq_done_count: got %0d required 1", sd_q.size());
        end else begin
            tests_run++;
            if (sd_q[0] - c0 != 2 + PULSE_W + GAP_W) begin
                tests_failed++;
                $display("FAIL single_seq_done_cycle: got %0d required %0d", sd_q[0] - c0, 2 + PULSE_W + GAP_W);
            end
        end
        tests_run++;
        if (pulse_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL single_pulse_cnt: got %0d required 1", pulse_cnt);
        end
    endtask

    task automatic test_burst();
        pulse_t     p;
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wl_i = 4'b0001 << i;
            exp_q.push_back(4'b0001 << i);
        end
        @(posedge clk); #1;
        wl_i = '0;
        wait_pulses(4, 80, "burst_pulses");
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
            p = obs_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (p.val !== e || p.width != PULSE_W) begin
                tests_failed++;
                $display("FAIL burst_pulse%0d: got %b width %0d required %b width %0d", i, p.val, p.width, e, PULSE_W);
            end
            if (i > 0) begin
                tests_run++;
                if (p.gap != GAP_W) begin
                    tests_failed++;
                    $display("FAIL burst_gap%0d: got %0d required %0d", i, p.gap, GAP_W);
                end
            end
        end
        tests_run++;
        if (overflow !== 1'b0 || pulse_cnt !== 8'd4) begin
            tests_failed++;
            $display("FAIL burst_flags: overflow %b pulse_cnt %0d required overflow 0 pulse_cnt 4", overflow, pulse_cnt);
        end
    endtask

    task automatic test_overflow();
        pulse_t     p;
        logic [3:0] e;
        do_reset();
        // Five fit (one head leaves while filling); the sixth meets a full queue.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            wl_i = 4'b0001 << (i % 4);
            if (i < 5) exp_q.push_back(4'b0001 << (i % 4));
        end
        @(posedge clk); #1;
        wl_i = '0;
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_flag: got %b required 1", overflow);
        end
        wait_pulses(5, 100, "overflow_pulses");
        repeat (20) @(posedge clk);
        #1;
        tests_run++;
        if (obs_q.size() != 5) begin
            tests_failed++;
            $display("FAIL overflow_pulse_count: got %0d required 5", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            p = obs_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (p.val !== e) begin
                tests_failed++;
                $display("FAIL overflow_order: got %b required %b", p.val, e);
            end
        end
        tests_run++;
        if (pulse_cnt !== 8'd5 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_end: pulse_cnt %0d overflow %b required 5 and 1", pulse_cnt, overflow);
        end
    endtask

    task automatic test_bad_grant();
        do_reset();
        @(posedge clk); #1;
        wl_i = 4'b0110;
        @(posedge clk); #1;
        wl_i = '0;
        tests_run++;
        if (err_onehot !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_grant_err: got %b required 1", err_onehot);
        end
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (busy !== 1'b0 || wl_en !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bad_grant_idle: cycle %0d busy %b wl_en %b required 0", i, busy, wl_en);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (err_onehot !== 1'b1 || obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bad_grant_sticky: err %b pulses %0d required err 1 pulses 0", err_onehot, obs_q.size());
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            wl_i = 4'b0100 >> (i * 2 % 4);
        end
        @(posedge clk); #1;
        wl_i = '0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (wl_en == 4'b0100) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL mid_reset_setup: wl_en %b required 0100", wl_en);
        end
        #3 rst = 1'b0;
        #1;
        tests_run++;
        if (wl_en !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_reset_async: wl_en %b required 0000", wl_en);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || pulse_cnt !== 8'd0 || obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL mid_reset_after: busy %b pulse_cnt %0d pulses %0d required 0 0 0", busy, pulse_cnt, obs_q.size());
        end
    endtask

    task automatic test_early_done();
        int c0;
        do_reset();
        @(posedge clk); #1;
        wl_i   = 4'b0001;
        done_i = 1'b1;
        c0     = cyc;
        @(posedge clk); #1;
        wl_i = 4'b0010;
        @(posedge clk); #1;
        wl_i = 4'b1000;
        @(posedge clk); #1;
        wl_i = '0;
        for (int i = 0; i < 80 && sd_q.size() == 0; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        tests_run++;
        if (sd_q.size() != 1) begin
            tests_failed++;
            $display("FAIL early_done_count: got %0d required 1", sd_q.size());
        end else begin
            tests_run++;
            if (sd_q[0] - c0 != 2 + 3 * (PULSE_W + GAP_W)) begin
                tests_failed++;
                $display("FAIL early_done_cycle: got %0d required %0d", sd_q[0] - c0, 2 + 3 * (PULSE_W + GAP_W));
            end
        end
        tests_run++;
        if (obs_q.size() != 3 || pulse_cnt !== 8'd3) begin
            tests_failed++;
            $display("FAIL early_done_pulses: pulses %0d pulse_cnt %0d required 3", obs_q.size(), pulse_cnt);
        end
    endtask

    initial begin
        rst    = 1'b0;
        wl_i   = '0;
        done_i = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_bad_grant();
        test_reset_mid_pulse();
        test_early_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
